// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and decode/issue.
// Head entry is presented first-word-fall-through; clr_in flushes on misprediction.
module instr_queue #(
  parameter int DEPTH_WIDTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clr_in,
  input  logic                   push_valid,
  input  logic [31:0]            push_instr,
  input  logic [31:0]            push_npc,
  input  logic                   pop_ready,
  output logic                   full,
  output logic [DEPTH_WIDTH:0]   count,
  output logic                   has_instr,
  output logic [31:0]            instr,
  output logic [31:0]            npc
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH + 1)'(DEPTH);

  logic [DEPTH_WIDTH-1:0] head;
  logic [DEPTH_WIDTH-1:0] tail;
  logic [31:0]            instr_mem [DEPTH];
  logic [31:0]            npc_mem   [DEPTH];

  logic do_push;
  logic do_pop;
  logic write_en;

  // Push/pop qualifiers use pre-edge state: a full queue drops a push even if
  // it pops this cycle, and an empty queue never bypasses a push to the head.
  assign has_instr = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign do_push   = push_valid & ~full;
  assign do_pop    = pop_ready & has_instr;
  assign write_en  = ~rst_in & rdy_in & ~clr_in & do_push;

  assign instr = has_instr ? instr_mem[head] : '0;
  assign npc   = has_instr ? npc_mem[head]   : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + 1'b1;
        if (do_pop)  head <= head + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the storage arrays are deliberately not reset; entries are only
  // ever read behind a valid count, so a reset would just cost logic.
  always_ff @(posedge clk_in) begin
    if (write_en) begin
      instr_mem[tail] <= push_instr;
      npc_mem[tail]   <= push_npc;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_instr_queue;

  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          rdy_in = 1'b1;
  logic          clr_in = 1'b0;
  logic          push_valid = 1'b0;
  logic [31:0]   push_instr = '0;
  logic [31:0]   push_npc = '0;
  logic          pop_ready = 1'b0;
  logic          full;
  logic [DW:0]   count;
  logic          has_instr;
  logic [31:0]   instr;
  logic [31:0]   npc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } entry_t;

  entry_t model_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  instr_queue #(.DEPTH_WIDTH(DW)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clr_in     (clr_in),
    .push_valid (push_valid),
    .push_instr (push_instr),
    .push_npc   (push_npc),
    .pop_ready  (pop_ready),
    .full       (full),
    .count      (count),
    .has_instr  (has_instr),
    .instr      (instr),
    .npc        (npc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue updated by the queue rules.
  task automatic model_update();
    bit m_full, m_has, m_push, m_pop;
    entry_t e;
    if (rst_in) begin
      model_q.delete();
    end else if (rdy_in) begin
      if (clr_in) begin
        model_q.delete();
      end else begin
        m_full = (model_q.size() == DEPTH);
        m_has  = (model_q.size() != 0);
        m_push = push_valid && !m_full;
        m_pop  = pop_ready && m_has;
        if (m_pop) void'(model_q.pop_front());
        if (m_push) begin
          e.instr = push_instr;
          e.npc   = push_npc;
          model_q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_outputs();
    int sz = model_q.size();
    check("count", 32'(count), 32'(sz));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("has_instr", 32'(has_instr), 32'(sz != 0));
    check("instr", instr, (sz != 0) ? model_q[0].instr : 32'h0);
    check("npc", npc, (sz != 0) ? model_q[0].npc : 32'h0);
  endtask

  // One clock: apply inputs, clock edge, update model, sample 1ns later.
  task automatic step(input bit pv, input logic [31:0] pi, input logic [31:0] pn,
                      input bit pr, input bit clr = 1'b0, input bit rdy = 1'b1,
                      input bit rst = 1'b0);
    push_valid = pv;
    push_instr = pi;
    push_npc   = pn;
    pop_ready  = pr;
    clr_in     = clr;
    rdy_in     = rdy;
    rst_in     = rst;
    @(posedge clk_in);
    model_update();
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset then idle
    step(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 0, 0, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_instr", instr, 32'h0);

    // Single push then pop
    step(1'b1, 32'h00500093, 32'h4, 1'b0);
    check("single_instr", instr, 32'h00500093);
    check("single_npc", npc, 32'h4);
    step(1'b0, 0, 0, 1'b1);
    check("single_pop_count", 32'(count), 32'd0);

    // Fill to 16, overflow push dropped, drain in order
    for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 32'(4 * i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    step(1'b1, 32'hFF, 32'hFF, 1'b0);
    check("overflow_count", 32'(count), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      check("drain_order", instr, 32'(i));
      step(1'b0, 0, 0, 1'b1);
    end
    check("drain_empty", 32'(has_instr), 32'd0);

    // Wrap: push 10, pop 10, push 12, pop all
    for (int i = 0; i < 10; i++) step(1'b1, 32'h100 + 32'(i), 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
    check("wrap_count", 32'(count), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check("wrap_order", instr, 32'h100 + 32'(i));
      step(1'b0, 0, 0, 1'b1);
    end

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) step(1'b1, 32'h300 + 32'(i), 32'(i), 1'b0);
    step(1'b1, 32'hAA, 32'hAA, 1'b1);
    check("full_pushpop_count", 32'(count), 32'd15);
    for (int i = 1; i < 16; i++) begin
      check("full_pushpop_noAA", 32'(instr == 32'hAA), 32'd0);
      step(1'b0, 0, 0, 1'b1);
    end

    // Empty with simultaneous push and pop
    step(1'b1, 32'hBB, 32'hB0, 1'b1);
    check("empty_pushpop_count", 32'(count), 32'd1);
    check("empty_pushpop_head", instr, 32'hBB);
    step(1'b0, 0, 0, 1'b1);

    // Clear with push, rdy low hold, reset while not ready
    for (int i = 0; i < 5; i++) step(1'b1, 32'h400 + 32'(i), 32'(i), 1'b0);
    step(1'b1, 32'h999, 32'h999, 1'b1, 1'b1);
    check("clr_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h500 + 32'(i), 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h777, 32'h777, 1'b1, 1'b0, 1'b0);
    check("hold_count", 32'(count), 32'd5);
    check("hold_head", instr, 32'h500);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_notrdy_count", 32'(count), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) < 60), $urandom, $urandom,
           ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 90),
           ($urandom_range(0, 999) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
